// File: rtl/icb_pkg.sv
`default_nettype none
// ============================================================================
//  Module : icb_pkg
//  Brief  : Shared ICB widths, arbitration mode names and master id type.
//  Rev    : 1.0 - initial release
// ============================================================================
package icb_pkg;

    localparam int ICB_ADDR_W = 32;
    localparam int ICB_DATA_W = 32;
    localparam int ICB_MASK_W = 4;

    localparam string ARB_MODE_RR    = "rr";
    localparam string ARB_MODE_FIXED = "fixed";

    // Master 0 is instruction fetch, master 1 is load/store
    typedef enum logic {
        MST0 = 1'b0,
        MST1 = 1'b1
    } mst_id_e;

    function automatic mst_id_e other_id(input mst_id_e id);
        return (id == MST0) ? MST1 : MST0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icb_arbiter_2to1_if.sv
`default_nettype none
// ============================================================================
//  Module : icb_arbiter_2to1_if
//  Brief  : One ICB link (command + response channels) with master/slave views.
//  Rev    : 1.0 - initial release
// ============================================================================
interface icb_arbiter_2to1_if;
    import icb_pkg::*;

    logic [ICB_ADDR_W-1:0] icb_cmd_addr;
    logic                  icb_cmd_read;
    logic [ICB_DATA_W-1:0] icb_cmd_wdata;
    logic [ICB_MASK_W-1:0] icb_cmd_wmask;
    logic                  icb_cmd_valid;
    logic                  icb_cmd_ready;
    logic [ICB_DATA_W-1:0] icb_rsp_rdata;
    logic                  icb_rsp_err;
    logic                  icb_rsp_valid;
    logic                  icb_rsp_ready;

    modport master (
        output icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_cmd_valid,
        input  icb_cmd_ready,
        input  icb_rsp_rdata, icb_rsp_err, icb_rsp_valid,
        output icb_rsp_ready
    );

    modport slave (
        input  icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask, icb_cmd_valid,
        output icb_cmd_ready,
        output icb_rsp_rdata, icb_rsp_err, icb_rsp_valid,
        input  icb_rsp_ready
    );

endinterface
`default_nettype wire

// File: rtl/icb_rsp_order_fifo.sv
`default_nettype none
// ============================================================================
//  Module : icb_rsp_order_fifo
//  Brief  : 1-bit register FIFO recording which master owns each outstanding
//           command, head exposed for response routing.
//  Rev    : 1.0 - initial release
// ============================================================================
module icb_rsp_order_fifo #(
    parameter int DEPTH = 2
) (
    input  wire  clk,
    input  wire  rst,
    input  wire  i_push,
    input  wire  i_push_id,
    input  wire  i_pop,
    output logic o_full,
    output logic o_empty,
    output logic o_head
);

    // A single-entry FIFO still gets two slots so the pointers stay non-degenerate;
    // the occupancy count alone limits it to one entry.
    localparam int c_mem_depth = (DEPTH < 2) ? 2 : DEPTH;
    localparam int c_ptr_w     = $clog2(c_mem_depth);
    localparam int c_cnt_w     = $clog2(DEPTH + 1);

    logic [c_mem_depth-1:0] r_mem;
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [c_cnt_w-1:0]     r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_id;
        end
    end

    assign o_full  = (r_count == c_cnt_w'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/icb_arbiter_2to1.sv
`default_nettype none
// ============================================================================
//  Module : icb_arbiter_2to1
//  Brief  : Two-master to one-slave ICB arbiter with in-order response routing.
//  Rev    : 1.0 - initial release
// ============================================================================
module icb_arbiter_2to1
    import icb_pkg::*;
#(
    parameter int    OUTSTANDING_DEPTH = 2,
    parameter string ARB_MODE          = ARB_MODE_RR
) (
    input  wire                     clk,
    input  wire                     rst,
    icb_arbiter_2to1_if.slave       s0,
    icb_arbiter_2to1_if.slave       s1,
    icb_arbiter_2to1_if.master      m,
    output logic                    rsp_orphan_err
);

    localparam bit c_fixed = (ARB_MODE == ARB_MODE_FIXED);

    mst_id_e w_grant;
    mst_id_e w_head_id;
    mst_id_e r_locked_id;
    mst_id_e r_rr_prio;
    logic    r_lock;
    logic    w_granted_valid;
    logic    w_can_issue;
    logic    w_cmd_hs;
    logic    w_rsp_hs;
    logic    w_full;
    logic    w_empty;
    logic    w_head;

    // Grant selection; a stalled command keeps its owner until the handshake
    always_comb begin
        w_grant = MST0;
        if (r_lock) begin
            w_grant = r_locked_id;
        end else if (!c_fixed && s0.icb_cmd_valid && s1.icb_cmd_valid) begin
            w_grant = r_rr_prio;
        end else begin
            w_grant = s0.icb_cmd_valid ? MST0 : MST1;
        end
    end

    assign w_can_issue     = ~w_full;
    assign w_granted_valid = (w_grant == MST1) ? s1.icb_cmd_valid : s0.icb_cmd_valid;

    always_comb begin
        m.icb_cmd_addr  = s0.icb_cmd_addr;
        m.icb_cmd_read  = s0.icb_cmd_read;
        m.icb_cmd_wdata = s0.icb_cmd_wdata;
        m.icb_cmd_wmask = s0.icb_cmd_wmask;
        if (w_grant == MST1) begin
            m.icb_cmd_addr  = s1.icb_cmd_addr;
            m.icb_cmd_read  = s1.icb_cmd_read;
            m.icb_cmd_wdata = s1.icb_cmd_wdata;
            m.icb_cmd_wmask = s1.icb_cmd_wmask;
        end
    end

    assign m.icb_cmd_valid = w_granted_valid & w_can_issue;

    // Ready is qualified by the granted master's valid so an idle port never sees ready
    assign s0.icb_cmd_ready = (w_grant == MST0) & w_granted_valid & m.icb_cmd_ready & w_can_issue;
    assign s1.icb_cmd_ready = (w_grant == MST1) & w_granted_valid & m.icb_cmd_ready & w_can_issue;

    assign w_cmd_hs = m.icb_cmd_valid & m.icb_cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock         <= 1'b0;
            r_locked_id    <= MST0;
            r_rr_prio      <= MST0;
            rsp_orphan_err <= 1'b0;
        end else begin
            if (w_cmd_hs) begin
                r_lock <= 1'b0;
            end else if (m.icb_cmd_valid) begin
                r_lock      <= 1'b1;
                r_locked_id <= w_grant;
            end
            if (w_cmd_hs && !c_fixed) begin
                r_rr_prio <= other_id(w_grant);
            end
            if (m.icb_rsp_valid && w_empty) begin
                rsp_orphan_err <= 1'b1;
            end
        end
    end

    icb_rsp_order_fifo #(
        .DEPTH     (OUTSTANDING_DEPTH)
    ) u_order_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_cmd_hs),
        .i_push_id (w_grant == MST1),
        .i_pop     (w_rsp_hs),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_head    (w_head)
    );

    assign w_head_id = mst_id_e'(w_head);

    assign s0.icb_rsp_valid = m.icb_rsp_valid & ~w_empty & (w_head_id == MST0);
    assign s1.icb_rsp_valid = m.icb_rsp_valid & ~w_empty & (w_head_id == MST1);
    assign s0.icb_rsp_rdata = m.icb_rsp_rdata;
    assign s1.icb_rsp_rdata = m.icb_rsp_rdata;
    assign s0.icb_rsp_err   = m.icb_rsp_err;
    assign s1.icb_rsp_err   = m.icb_rsp_err;

    assign m.icb_rsp_ready = ~w_empty &
                             ((w_head_id == MST1) ? s1.icb_rsp_ready : s0.icb_rsp_ready);
    assign w_rsp_hs        = m.icb_rsp_valid & m.icb_rsp_ready;

endmodule
`default_nettype wire
